stage2_adder: RTL
=================

# stage2_adder

Second stage of the pipelined 8-input adder tree. It takes the four registered 8-bit partial sums from stage 1 and adds them in pairs, (s0+s1) and (s2+s3). It produces two zero-extended 9-bit sums for stage 3. A valid/ready handshake with a one-entry skid buffer lets the downstream stage stall without dropping or reordering any beat, and a beat counter supports debug and verification.

## Interface
Parameters:
- IN_W, 8, width of each incoming partial sum.
- OUT_W, IN_W+1, width of each outgoing sum; fixed relation, not independently overridable.
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- s_valid  input  1  upstream beat present on s0..s3.
- s_ready  output  1  block can accept a beat this cycle.
- s0, s1, s2, s3  input  IN_W each  partial sums from stage 1.
- m_valid  output  1  p0/p1 hold a valid beat.
- m_ready  input  1  downstream accepts p0/p1 this cycle.
- p0  output  OUT_W  registered s0+s1.
- p1  output  OUT_W  registered s2+s3.
- beat_cnt  output  CNT_W  number of accepted input beats, modulo 2^CNT_W.

## Operation
- Input transfer ("accept") occurs when s_valid && s_ready at a rising edge. Output transfer ("drain") occurs when m_valid && m_ready.
- Arithmetic: p0 = {1'b0,s0} + {1'b0,s1}; p1 = {1'b0,s2} + {1'b0,s3}. The sums are unsigned and never overflow (max 255+255 = 510).
- Storage: an output register (out_data, m_valid) and one skid register (skid_data, skid_valid).
- s_ready = !skid_valid, derived directly from the register with no combinational path from m_ready.
- Per-edge update, evaluated in priority order:
  - Skid full and drain: out_data <= skid_data; skid_valid <= 0; m_valid stays 1.
  - Accept with the output empty or draining: out_data <= new sums; m_valid <= 1.
  - Accept with the output full and not draining: skid_data <= new sums; skid_valid <= 1.
  - Drain with no accept and skid empty: m_valid <= 0. out_data holds its last value.
  - Otherwise: hold.
- An accept cannot occur while the skid is full, because s_ready is 0.
- Beats leave in exactly the order they were accepted. No beat is lost or duplicated.
- p0/p1 must stay stable while m_valid=1 and m_ready=0.
- beat_cnt increments by 1 on each accept and wraps from 2^CNT_W-1 to 0.
- States, as {m_valid, skid_valid}:
  - EMPTY (0,0) → ONE on accept.
  - ONE (1,0):
    - → EMPTY on drain with no accept.
    - → ONE on accept with drain.
    - → FULL on accept with no drain.
  - FULL (1,1) → ONE on drain. Holds otherwise.
  - State (0,1) is unreachable.

## Timing
- Reset (asynchronous assert, synchronous release by clk edge):
  - m_valid=0, skid_valid=0, hence s_ready=1.
  - p0=0, p1=0, skid_data=0, beat_cnt=0.
  - s_ready reads 1 while rst is high. Accepts are ignored until rst is low at a rising edge.
- Latency: the sums appear on p0/p1 with m_valid=1 one cycle after the accept edge, provided the output was empty or draining.
- Throughput: one beat per cycle while m_ready=1.
- Backpressure:
  - s_ready falls in the cycle after the stalled beat lands in the skid.
  - s_ready rises in the cycle after the skid drains.
  - At most one extra beat is accepted after m_ready drops.
- Reset mid-operation discards all held beats immediately: m_valid and s_ready take their reset values without waiting for a clock edge.
- Simultaneous accept and drain in ONE keeps m_valid=1 with the new data and no bubble.

## Test plan
- Reset, then accept s0..s3 = 01,02,03,04 with m_ready=1 → next cycle m_valid=1, p0=0x003, p1=0x007, beat_cnt=1. The following cycle (s_valid=0) → m_valid=0.
- Max values: s0..s3 = FF,FF,80,80 → p0=0x1FE, p1=0x100, with no truncation.
- Stall:
  - Stimulus: m_ready=0, two back-to-back beats A (01,01,01,01) then B (02,02,02,02).
  - Required while stalled: p0 stays 0x002, s_ready=0 after B is accepted, and a third beat C is not accepted.
  - Required after m_ready=1: A drains, then B (p0=0x004), then C, in that order.
- Streaming 100 random beats, s_valid and m_ready both randomly toggled → scoreboard matches every beat in order, and beat_cnt=100.
- Assert rst asynchronously between edges while in FULL → m_valid=0, s_ready=1, p0=p1=0, beat_cnt=0 immediately. No stale beat appears after release.
- Preload beat_cnt to 0xFFFF via 65535 accepts, then one more accept → beat_cnt wraps to 0x0000.

Source files
------------

// File: rtl/stage2_adder.sv
// Adder-tree stage 2: pairwise sums of four stage-1 partials, with a one-entry
// skid buffer so the downstream stage can stall without losing or reordering beats.
module stage2_adder #(
  parameter int IN_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s0,
  input  logic [IN_W-1:0]       s1,
  input  logic [IN_W-1:0]       s2,
  input  logic [IN_W-1:0]       s3,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [IN_W:0]         p0,
  output logic [IN_W:0]         p1,
  output logic [CNT_W-1:0]      beat_cnt
);

  localparam int OUT_W = IN_W + 1;

  function automatic logic [OUT_W-1:0] pair_sum(input logic [IN_W-1:0] a,
                                                input logic [IN_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [OUT_W-1:0] sum0_p0, sum1_p0;
  logic [OUT_W-1:0] out0_p1, out1_p1;
  logic [OUT_W-1:0] skid0_p1, skid1_p1;
  logic             vld_p1, skid_vld_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             accept, drain;

  // Stage 0: combinational pair sums of the incoming partials
  assign sum0_p0 = pair_sum(s0, s1);
  assign sum1_p0 = pair_sum(s2, s3);

  assign s_ready = !skid_vld_p1;
  assign accept  = s_valid && s_ready;
  assign drain   = vld_p1 && m_ready;

  // Stage 1: output register backed by a single skid entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out0_p1     <= '0;
      out1_p1     <= '0;
      skid0_p1    <= '0;
      skid1_p1    <= '0;
      cnt_p1      <= '0;
    end else begin
      if (skid_vld_p1 && drain) begin
        out0_p1     <= skid0_p1;
        out1_p1     <= skid1_p1;
        skid_vld_p1 <= 1'b0;
      end else if (accept && (!vld_p1 || m_ready)) begin
        out0_p1 <= sum0_p0;
        out1_p1 <= sum1_p0;
        vld_p1  <= 1'b1;
      end else if (accept) begin
        skid0_p1    <= sum0_p0;
        skid1_p1    <= sum1_p0;
        skid_vld_p1 <= 1'b1;
      end else if (drain) begin
        vld_p1 <= 1'b0;
      end
      if (accept)
        cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  assign m_valid  = vld_p1;
  assign p0       = out0_p1;
  assign p1       = out1_p1;
  assign beat_cnt = cnt_p1;

endmodule
